capture_ctrl: RTL
=================

Name: capture_ctrl

Overview:
Capture controller that sits directly upstream of the RAM interface and produces its capture-side inputs: we, cap_en, cap_addr and trace_end.
- Writes decimated samples into a circular trace buffer of DEPTH entries.
- Guarantees trig_pos pre-trigger samples before it accepts a trigger, then fills the rest of the buffer.
- Latches the address of the last written sample as trace_end and holds until the dump completes.

Parameters:
DEPTH, 512, trace buffer entries; must equal 2^AW.
AW, 9, address width of cap_addr and trace_end.

Ports:
clk  input  1  system clock; all logic on the rising edge.
rst  input  1  synchronous, active-high reset.
capture_start  input  1  single-cycle pulse that starts a capture; honoured only in IDLE.
trig_pos  input  AW  number of pre-trigger samples; sampled on capture_start.
decimator  input  4  a sample is taken every 2^decimator clocks; sampled on capture_start.
trig_in  input  1  trigger level from the trigger logic; rising edge detected internally.
dump_done  input  1  single-cycle pulse at the end of a dump; honoured only in DONE.
we  output  1  high while capturing (PRETRIG, ARMED, POSTTRIG).
cap_en  output  1  one-cycle write strobe per sample.
cap_addr  output  AW  write address, valid when cap_en is high.
trace_end  output  AW  address of the last sample written by the most recent capture.
armed  output  1  high in ARMED.
capture_done  output  1  high in DONE.

Behaviour:
- Reset: synchronous, active-high, takes effect on the next clk edge, including mid-capture.
  - State goes to IDLE; wptr, dec_cnt, sample counters, trace_end and trig_q all go to 0.
  - Outputs after reset: we=0, cap_en=0, cap_addr=0, trace_end=0, armed=0, capture_done=0.
- Output timing: outputs are decoded only from registers; there is no combinational path from input to output.
- States: IDLE, PRETRIG, ARMED, POSTTRIG, DONE.
- IDLE, on capture_start:
  - Latch tp = min(trig_pos, DEPTH-1) and dec = decimator.
  - Clear wptr, dec_cnt and pre_cnt.
  - Next state is PRETRIG if tp!=0, else ARMED.
- Sample tick: tick = we & (dec_cnt==0).
  - dec_cnt increments modulo 2^dec every cycle while we=1.
  - With dec=0, tick is asserted every cycle.
  - The first tick occurs in the first cycle after capture_start.
- Each tick: cap_en=1 with cap_addr=wptr; wptr <= wptr+1, wrapping from DEPTH-1 to 0.
- PRETRIG:
  - Each tick increments pre_cnt.
  - On the tick where pre_cnt==tp-1, move to ARMED.
  - Triggers are ignored in PRETRIG.
- ARMED:
  - Writes continue on every tick.
  - trig_edge = trig_in & ~trig_q, where trig_q is the registered trig_in.
  - On trig_edge, move to POSTTRIG and load post_cnt=DEPTH-tp.
  - A tick in the same cycle as trig_edge is written in ARMED.
- POSTTRIG:
  - Writes exactly DEPTH-tp further samples; each tick decrements post_cnt.
  - On the tick where post_cnt==1: trace_end <= wptr (the address being written), then move to DONE.
  - Triggers are ignored.
- DONE:
  - we=0 and cap_en=0; trace_end is held.
  - dump_done returns the block to IDLE.
  - capture_start is ignored.
- Ignored events:
  - capture_start outside IDLE is ignored, including when it coincides with dump_done in DONE.
  - dump_done outside DONE is ignored.
- Address arithmetic: all address math is modulo DEPTH. After a capture, trace_end+1 is the oldest sample, so a dump from trace_end+1 through trace_end covers exactly DEPTH samples.
- Held registers: trace_end is updated only on the final POSTTRIG write; otherwise it keeps its value across captures.

Test Plan:
1. Normal capture, no decimation.
   - Stimulus: rst, then decimator=0, trig_pos=4, capture_start at cycle 0; trig_in rises at cycle 10.
   - Required: cap_en cycles 1-4 at addresses 0-3; armed from cycle 5; addresses 4-9 written at cycles 5-10; POSTTRIG writes 508 samples at cycles 11-518, addresses 10..511 then 0..5; trace_end=5; capture_done=1 at cycle 519.
2. Decimation.
   - Stimulus: decimator=2, trig_pos=1.
   - Required: cap_en every 4th cycle, starting in the first cycle after capture_start; cap_addr increments by 1 per strobe; we stays high between strobes.
3. trig_pos=0 and trig_pos clamp.
   - Stimulus: run with trig_pos=0, then with trig_pos=511.
   - Required, trig_pos=0: ARMED the cycle after start; after a trigger, 512 post samples are written.
   - Required, trig_pos=511: 511 pre-trigger writes, then exactly 1 post-trigger write.
4. Early and held triggers.
   - Stimulus: trig_in pulses during PRETRIG; separately, trig_in is held high from start.
   - Required: the PRETRIG pulse is ignored. With trig_in held high there is no edge in ARMED, so the block stays armed until trig_in falls and rises again.
5. Handshake protection.
   - Stimulus: capture_start during ARMED; dump_done during POSTTRIG; capture_start together with dump_done in DONE.
   - Required: the first two are ignored with state unchanged; the last returns to IDLE with no new capture started.
6. Reset mid-capture.
   - Stimulus: rst asserted for one cycle in POSTTRIG.
   - Required: the next cycle shows IDLE with we=0, cap_en=0, cap_addr=0, trace_end=0 and armed=0. A fresh capture afterwards starts writing at address 0.

Source files
------------

// File: rtl/capture_ctrl_if.sv
`timescale 1ns/1ps
`default_nettype none
//============================================================================
// Module : capture_ctrl_if
// Brief  : Command, trigger and RAM-side capture signals of capture_ctrl.
// Rev    : 1.0 - initial release
//============================================================================
interface capture_ctrl_if #(
    parameter int AW = 9
);
    logic          capture_start;
    logic [AW-1:0] trig_pos;
    logic [3:0]    decimator;
    logic          trig_in;
    logic          dump_done;
    logic          we;
    logic          cap_en;
    logic [AW-1:0] cap_addr;
    logic [AW-1:0] trace_end;
    logic          armed;
    logic          capture_done;

    modport master (
        output capture_start, trig_pos, decimator, trig_in, dump_done,
        input  we, cap_en, cap_addr, trace_end, armed, capture_done
    );

    modport slave (
        input  capture_start, trig_pos, decimator, trig_in, dump_done,
        output we, cap_en, cap_addr, trace_end, armed, capture_done
    );
endinterface
`default_nettype wire

// File: rtl/capture_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
//============================================================================
// Module : capture_ctrl
// Brief  : Circular trace-buffer capture controller with pre-trigger fill,
//          edge-triggered arming and post-trigger completion.
// Rev    : 1.0 - initial release
//============================================================================
module capture_ctrl #(
    parameter int DEPTH = 512,
    parameter int AW    = 9
) (
    input  wire logic        clk,
    input  wire logic        rst,
    capture_ctrl_if.slave    cif
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_PRETRIG  = 3'd1;
    localparam logic [2:0] S_ARMED    = 3'd2;
    localparam logic [2:0] S_POSTTRIG = 3'd3;
    localparam logic [2:0] S_DONE     = 3'd4;

    localparam logic [AW-1:0] c_ADDR_ONE = AW'(1);
    localparam logic [AW:0]   c_POST_ONE = (AW+1)'(1);
    localparam logic [AW:0]   c_DEPTH    = (AW+1)'(DEPTH);
    localparam logic [14:0]   c_DEC_ONE  = 15'd1;

    logic [2:0]    r_state;
    logic [2:0]    w_state_nxt;
    logic [AW-1:0] r_tp;
    logic [3:0]    r_dec;
    logic [14:0]   r_dec_cnt;
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_pre_cnt;
    logic [AW:0]   r_post_cnt;
    logic [AW-1:0] r_trace_end;
    logic          r_trig_q;

    logic          w_we;
    logic          w_tick;
    logic          w_trig_edge;
    logic          w_pre_last;
    logic          w_post_last;
    logic          w_start;
    logic [14:0]   w_dec_mask;

    assign w_we        = (r_state == S_PRETRIG) || (r_state == S_ARMED) ||
                         (r_state == S_POSTTRIG);
    assign w_tick      = w_we && (r_dec_cnt == '0);
    assign w_trig_edge = cif.trig_in && !r_trig_q;
    assign w_pre_last  = (r_pre_cnt == (r_tp - c_ADDR_ONE));
    assign w_post_last = (r_post_cnt == c_POST_ONE);
    assign w_start     = (r_state == S_IDLE) && cif.capture_start;
    assign w_dec_mask  = (c_DEC_ONE << r_dec) - c_DEC_ONE;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (cif.capture_start) begin
                    w_state_nxt = (cif.trig_pos != '0) ? S_PRETRIG : S_ARMED;
                end
            end
            S_PRETRIG: begin
                if (w_tick && w_pre_last) begin
                    w_state_nxt = S_ARMED;
                end
            end
            S_ARMED: begin
                if (w_trig_edge) begin
                    w_state_nxt = S_POSTTRIG;
                end
            end
            S_POSTTRIG: begin
                if (w_tick && w_post_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (cif.dump_done) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tp        <= '0;
            r_dec       <= '0;
            r_dec_cnt   <= '0;
            r_wptr      <= '0;
            r_pre_cnt   <= '0;
            r_post_cnt  <= '0;
            r_trace_end <= '0;
            r_trig_q    <= 1'b0;
        end else begin
            r_trig_q <= cif.trig_in;
            // An AW-bit trig_pos can never exceed DEPTH-1, so the clamp is implicit.
            if (w_start) begin
                r_tp      <= cif.trig_pos;
                r_dec     <= cif.decimator;
                r_dec_cnt <= '0;
                r_wptr    <= '0;
                r_pre_cnt <= '0;
            end
            if (w_we) begin
                r_dec_cnt <= (r_dec_cnt + c_DEC_ONE) & w_dec_mask;
            end
            // DEPTH is a power of two, so the natural wrap of wptr is the modulo.
            if (w_tick) begin
                r_wptr <= r_wptr + c_ADDR_ONE;
            end
            if ((r_state == S_PRETRIG) && w_tick) begin
                r_pre_cnt <= r_pre_cnt + c_ADDR_ONE;
            end
            if ((r_state == S_ARMED) && w_trig_edge) begin
                r_post_cnt <= c_DEPTH - {1'b0, r_tp};
            end
            if ((r_state == S_POSTTRIG) && w_tick) begin
                r_post_cnt <= r_post_cnt - c_POST_ONE;
                if (w_post_last) begin
                    r_trace_end <= r_wptr;
                end
            end
        end
    end

    assign cif.we           = w_we;
    assign cif.cap_en       = w_tick;
    assign cif.cap_addr     = r_wptr;
    assign cif.trace_end    = r_trace_end;
    assign cif.armed        = (r_state == S_ARMED);
    assign cif.capture_done = (r_state == S_DONE);

endmodule
`default_nettype wire
